// File: rtl/dai_rx.sv
// dai_rx: I2S receiver that oversamples BCK/LRCK/SData, deserializes L/R words
// and emits truncated stereo pairs with a wrapping buffer address. Rev 1.0
`default_nettype none

module dai_rx #(
  parameter int bw_sample  = 16,
  parameter int bw_out     = 9,
  parameter int bw_romaddr = 6
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  BCK,
  input  logic                  LRCK,
  input  logic                  SData,
  output logic [bw_out-1:0]     DataL,
  output logic [bw_out-1:0]     DataR,
  output logic [bw_romaddr-1:0] WrAddr,
  output logic                  SampleValid,
  output logic                  FrameDone,
  output logic                  SyncErr
);

  localparam int CW = $clog2(bw_sample + 1);

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    SHIFT_L   = 2'd1,
    SHIFT_R   = 2'd2
  } state_t;

  state_t state, state_d;

  logic bck_s1, bck_s2, bck_d;
  logic lr_s1, lr_s2, lr_prev;
  logic sd_s1, sd_s2;

  logic [CW-1:0]         bitcnt;
  logic [bw_sample-1:0]  left_sr;
  logic [bw_sample-1:0]  right_sr;
  logic [bw_out-1:0]     left_hold;
  logic [bw_romaddr-1:0] addr_cnt;

  logic bck_rise, ws_change, ws_fall, ws_rise, slot_full;
  logic commit, err, latch_l;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      bck_s1 <= 1'b0;
      bck_s2 <= 1'b0;
      bck_d  <= 1'b0;
      lr_s1  <= 1'b0;
      lr_s2  <= 1'b0;
      sd_s1  <= 1'b0;
      sd_s2  <= 1'b0;
    end else begin
      bck_s1 <= BCK;
      bck_s2 <= bck_s1;
      bck_d  <= bck_s2;
      lr_s1  <= LRCK;
      lr_s2  <= lr_s1;
      sd_s1  <= SData;
      sd_s2  <= sd_s1;
    end
  end

  assign bck_rise  = bck_s2 & ~bck_d;
  assign ws_change = bck_rise & (lr_s2 != lr_prev);
  assign ws_fall   = ws_change & ~lr_s2;
  assign ws_rise   = ws_change & lr_s2;
  assign slot_full = (bitcnt == CW'(bw_sample));

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state <= WAIT_SYNC;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    commit  = 1'b0;
    err     = 1'b0;
    latch_l = 1'b0;
    case (state)
      WAIT_SYNC: begin
        if (ws_fall) state_d = SHIFT_L;
      end
      SHIFT_L: begin
        if (ws_rise) begin
          if (slot_full) begin
            latch_l = 1'b1;
            state_d = SHIFT_R;
          end else begin
            err     = 1'b1;
            state_d = WAIT_SYNC;
          end
        end
      end
      SHIFT_R: begin
        // A short right slot still leaves a valid left slot starting here.
        if (ws_fall) begin
          state_d = SHIFT_L;
          if (slot_full) commit = 1'b1;
          else           err    = 1'b1;
        end
      end
      default: state_d = WAIT_SYNC;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      lr_prev   <= 1'b0;
      bitcnt    <= '0;
      left_sr   <= '0;
      right_sr  <= '0;
      left_hold <= '0;
    end else begin
      if (bck_rise) lr_prev <= lr_s2;
      // The change bit is the previous slot's LSB and is dropped.
      if (ws_change) begin
        bitcnt <= '0;
      end else if (bck_rise && !slot_full) begin
        bitcnt <= bitcnt + CW'(1);
        if (lr_s2) right_sr <= {right_sr[bw_sample-2:0], sd_s2};
        else       left_sr  <= {left_sr[bw_sample-2:0], sd_s2};
      end
      if (latch_l) left_hold <= left_sr[bw_sample-1 -: bw_out];
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      DataL       <= '0;
      DataR       <= '0;
      WrAddr      <= '0;
      SampleValid <= 1'b0;
      FrameDone   <= 1'b0;
      SyncErr     <= 1'b0;
      addr_cnt    <= '0;
    end else begin
      SampleValid <= commit;
      SyncErr     <= err;
      FrameDone   <= commit & (&addr_cnt);
      if (commit) begin
        DataL    <= left_hold;
        DataR    <= right_sr[bw_sample-1 -: bw_out];
        WrAddr   <= addr_cnt;
        addr_cnt <= addr_cnt + bw_romaddr'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dai_rx.sv
// tb_dai_rx: randomized I2S traffic against a slot-level reference model. Rev 1.0
`default_nettype none

module tb_dai_rx;

  logic       Clock, Reset, BCK, LRCK, SData;
  logic [8:0] DataL, DataR;
  logic [5:0] WrAddr;
  logic       SampleValid, FrameDone, SyncErr;

  dai_rx #(.bw_sample(16), .bw_out(9), .bw_romaddr(6)) dut (
    .Clock(Clock), .Reset(Reset), .BCK(BCK), .LRCK(LRCK), .SData(SData),
    .DataL(DataL), .DataR(DataR), .WrAddr(WrAddr),
    .SampleValid(SampleValid), .FrameDone(FrameDone), .SyncErr(SyncErr)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    bit         err;
    logic [8:0] dl;
    logic [8:0] dr;
    logic [5:0] addr;
    bit         fd;
  } ev_t;

  ev_t exp_q[$];

  // Slot-level model: 0 = waiting for a left slot, 1 = in left, 2 = in right.
  int         m_phase;
  logic [8:0] m_hold, m_dl, m_dr;
  logic [5:0] m_addr, m_wr;

  function automatic logic [8:0] trunc(input logic [15:0] w);
    return 9'(w >> 7);
  endfunction

  function automatic void model_reset();
    m_phase = 0;
    m_addr  = 0;
    m_wr    = 0;
    m_dl    = 0;
    m_dr    = 0;
    m_hold  = 0;
    exp_q.delete();
  endfunction

  function automatic void push_err();
    ev_t e;
    e.err = 1; e.dl = m_dl; e.dr = m_dr; e.addr = m_wr; e.fd = 0;
    exp_q.push_back(e);
  endfunction

  function automatic void model_slot_end(input bit ch, input logic [15:0] w, input int len);
    bit   complete;
    ev_t  e;
    complete = (len - 1) >= 16;
    case (m_phase)
      0: if (ch) m_phase = 1;
      1: begin
        if (complete) begin
          m_hold  = trunc(w);
          m_phase = 2;
        end else begin
          push_err();
          m_phase = 0;
        end
      end
      default: begin
        if (complete) begin
          m_dl = m_hold; m_dr = trunc(w); m_wr = m_addr;
          e.err = 0; e.dl = m_dl; e.dr = m_dr; e.addr = m_wr; e.fd = (m_addr == 6'd63);
          exp_q.push_back(e);
          m_addr = m_addr + 6'd1;
        end else begin
          push_err();
        end
        m_phase = 1;
      end
    endcase
  endfunction

  time t_rise = 0;
  always @(posedge BCK) t_rise = $time;

  always @(negedge Clock) begin
    ev_t e;
    if (SampleValid || SyncErr) begin
      check("latency", 32'($time - t_rise), 32'd30);
      check("valid_err_excl", 32'(SampleValid & SyncErr), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_event", {31'd0, SampleValid}, {31'd0, 1'b0});
      end else begin
        e = exp_q.pop_front();
        check("kind_err",  32'(SyncErr), 32'(e.err));
        check("DataL",     32'(DataL),   32'(e.dl));
        check("DataR",     32'(DataR),   32'(e.dr));
        check("WrAddr",    32'(WrAddr),  32'(e.addr));
        check("FrameDone", 32'(FrameDone), 32'(e.fd));
      end
    end else if (FrameDone) begin
      check("framedone_alone", 32'(FrameDone), 32'd0);
    end
  end

  bit          have_prev = 0;
  bit          prev_ch;
  logic [15:0] prev_w;
  int          prev_len;
  logic        carry = 1'b0;

  task automatic send_bit(input logic lr, input logic d);
    @(negedge Clock);
    BCK = 1'b0; LRCK = lr; SData = d;
    repeat (4) @(negedge Clock);
    BCK = 1'b1;
    repeat (3) @(negedge Clock);
  endtask

  function automatic logic sbit(input logic [15:0] w, input int j);
    logic [15:0] t;
    t = w;
    return (j < 16) ? t[15-j] : 1'b0;
  endfunction

  task automatic send_slot(input bit ch, input logic [15:0] w, input int len, input int rst_bit);
    if (have_prev) model_slot_end(prev_ch, prev_w, prev_len);
    for (int k = 0; k < len; k++) begin
      send_bit(ch, (k == 0) ? carry : sbit(w, k - 1));
      if (k == rst_bit) begin
        check("q_empty_before_rst", 32'(exp_q.size()), 32'd0);
        Reset = 1'b0;
        @(negedge Clock);
        check("rst_DataL",  32'(DataL), 32'd0);
        check("rst_DataR",  32'(DataR), 32'd0);
        check("rst_WrAddr", 32'(WrAddr), 32'd0);
        check("rst_valid",  32'(SampleValid), 32'd0);
        model_reset();
        Reset = 1'b1;
      end
    end
    carry = sbit(w, len - 1);
    prev_ch = ch; prev_w = w; prev_len = len; have_prev = 1;
  endtask

  task automatic send_frame(input logic [15:0] l, input int ll, input logic [15:0] r, input int lr);
    send_slot(1'b0, l, ll, -1);
    send_slot(1'b1, r, lr, -1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_DataL"},  32'(DataL), 32'd0);
    check({tag, "_DataR"},  32'(DataR), 32'd0);
    check({tag, "_WrAddr"}, 32'(WrAddr), 32'd0);
    check({tag, "_flags"},  32'({SampleValid, FrameDone, SyncErr}), 32'd0);
  endtask

  initial begin
    Reset = 1'b0; BCK = 1'b0; LRCK = 1'b0; SData = 1'b0;
    model_reset();

    // Reset held across live traffic.
    fork
      send_slot(1'b0, 16'(($urandom)), 32, -1);
      begin
        repeat (12) @(negedge Clock);
        check_outputs_zero("rst_hold");
      end
    join
    check_outputs_zero("rst_end");
    Reset = 1'b1;

    // Traffic resumes mid right slot, then a directed frame.
    send_slot(1'b1, 16'($urandom), 12, -1);
    send_frame(16'h7FFF, 32, 16'h8001, 32);

    // Right slot cut short.
    send_frame(16'($urandom), 32, 16'($urandom), 10);

    for (int i = 0; i < 68; i++)
      send_frame(16'($urandom), 17 + int'($urandom_range(3)), 16'($urandom), 17 + int'($urandom_range(3)));

    for (int i = 0; i < 30; i++) begin
      int ll, lr;
      ll = 17 + int'($urandom_range(15));
      lr = 17 + int'($urandom_range(15));
      if ($urandom_range(7) == 0) lr = 10;
      if ($urandom_range(15) == 0) ll = 5 + int'($urandom_range(11));
      send_frame(16'($urandom), ll, 16'($urandom), lr);
    end

    // Single-cycle reset in the middle of a left slot.
    send_slot(1'b0, 16'($urandom), 32, 10);
    send_slot(1'b1, 16'($urandom), 32, -1);
    for (int i = 0; i < 3; i++)
      send_frame(16'($urandom), 24, 16'($urandom), 24);

    send_slot(1'b0, 16'($urandom), 20, -1);
    repeat (40) @(negedge Clock);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_addr_after_rst", 32'(WrAddr), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
